pair_buf_loader: RTL

//  Write-side counterpart of the iq_demod pair selector: accepts a stream of 5-bit sample pairs
//  and fills a 10-entry frame buffer, pair slot 0..4 in order. Exposes the full frame
//  (in_0..in_9) plus the 3-bit slot index to downstream pair-select logic.

---
 rtl/iq_demod_pkg.sv | 10 +
 rtl/pair_slot_ctr.sv | 24 ++
 rtl/pair_buf_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/iq_demod_pkg.sv
// Shared types and sizes for the iq_demod sample path.
package iq_demod_pkg;
    localparam int SAMPLE_W = 5;
    localparam int NPAIR    = 5;
    localparam int SEL_W    = 3;
    localparam int NSAMP    = 2 * NPAIR;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef enum logic {FILL, HOLD} ld_state_t;
endpackage

// File: rtl/pair_slot_ctr.sv
// Write-slot counter for the pair loader: counts 0..NPAIR-1, wraps after the last slot.
module pair_slot_ctr
    import iq_demod_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_last
);
    logic [SEL_W-1:0] r_sel;

    assign o_sel  = r_sel;
    assign o_last = (r_sel == SEL_W'(NPAIR - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_sel <= '0;
        end else if (i_inc) begin
            r_sel <= o_last ? '0 : r_sel + SEL_W'(1);
        end
    end
endmodule

// File: rtl/pair_buf_loader.sv
// Fills a 10-sample frame from 5 sample pairs and presents it downstream with a valid/ready handshake.
// Optional PAIR_BUF_DBL_EN adds a fill bank so the next frame can load while the current one is held.
module pair_buf_loader
    import iq_demod_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  sample_t          i_s_a,
    input  sample_t          i_s_b,
    output logic [SEL_W-1:0] o_wr_sel,
    output logic             o_f_valid,
    input  logic             i_f_ready,
    output sample_t          o_out_0,
    output sample_t          o_out_1,
    output sample_t          o_out_2,
    output sample_t          o_out_3,
    output sample_t          o_out_4,
    output sample_t          o_out_5,
    output sample_t          o_out_6,
    output sample_t          o_out_7,
    output sample_t          o_out_8,
    output sample_t          o_out_9
);
    ld_state_t        r_state;
    ld_state_t        w_state_nxt;
    sample_t          r_out [NSAMP];
    sample_t          w_bank_nxt [NSAMP];
    logic             w_accept;
    logic             w_last;
    logic             w_s_ready;
    logic             w_f_valid;
    logic [SEL_W-1:0] w_wr_sel;

    assign w_accept = i_s_valid && w_s_ready && !i_clr;

    pair_slot_ctr u_slot_ctr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (i_clr),
        .i_inc  (w_accept),
        .o_sel  (w_wr_sel),
        .o_last (w_last)
    );

`ifdef PAIR_BUF_DBL_EN
    // HOLD here means the fill bank is complete and waiting for the output bank to free up.
    sample_t r_fill [NSAMP];
    logic    r_f_valid;
    logic    w_out_free;
    logic    w_swap;

    assign w_out_free = !r_f_valid || i_f_ready;
    assign w_swap = !i_clr &&
                    (((r_state == FILL) && w_accept && w_last && w_out_free) ||
                     ((r_state == HOLD) && i_f_ready));

    always_comb begin
        w_state_nxt = r_state;
        if (i_clr) begin
            w_state_nxt = FILL;
        end else begin
            case (r_state)
                FILL:    if (w_accept && w_last && !w_out_free) w_state_nxt = HOLD;
                HOLD:    if (i_f_ready) w_state_nxt = FILL;
                default: w_state_nxt = FILL;
            endcase
        end
    end

    always_comb begin
        w_s_ready = !((r_state == HOLD) && !i_f_ready);
        w_f_valid = r_f_valid;
    end

    always_comb begin
        for (int j = 0; j < NSAMP; j++) w_bank_nxt[j] = r_fill[j];
        for (int k = 0; k < NPAIR; k++) begin
            if (w_accept && (w_wr_sel == SEL_W'(k))) begin
                w_bank_nxt[2*k]   = i_s_a;
                w_bank_nxt[2*k+1] = i_s_b;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_f_valid <= 1'b0;
            for (int j = 0; j < NSAMP; j++) begin
                r_fill[j] <= '0;
                r_out[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < NSAMP; j++) r_fill[j] <= w_bank_nxt[j];
            if (i_clr) begin
                r_f_valid <= 1'b0;
            end else if (w_swap) begin
                r_f_valid <= 1'b1;
                // A waiting bank is already complete; a pair accepted now belongs to the next frame.
                for (int j = 0; j < NSAMP; j++)
                    r_out[j] <= (r_state == HOLD) ? r_fill[j] : w_bank_nxt[j];
            end else if (i_f_ready) begin
                r_f_valid <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        w_state_nxt = r_state;
        if (i_clr) begin
            w_state_nxt = FILL;
        end else begin
            case (r_state)
                FILL:    if (w_accept && w_last) w_state_nxt = HOLD;
                HOLD:    if (i_f_ready) w_state_nxt = FILL;
                default: w_state_nxt = FILL;
            endcase
        end
    end

    always_comb begin
        w_s_ready = (r_state == FILL);
        w_f_valid = (r_state == HOLD);
    end

    always_comb begin
        for (int j = 0; j < NSAMP; j++) w_bank_nxt[j] = r_out[j];
        for (int k = 0; k < NPAIR; k++) begin
            if (w_accept && (w_wr_sel == SEL_W'(k))) begin
                w_bank_nxt[2*k]   = i_s_a;
                w_bank_nxt[2*k+1] = i_s_b;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < NSAMP; j++) r_out[j] <= '0;
        end else begin
            for (int j = 0; j < NSAMP; j++) r_out[j] <= w_bank_nxt[j];
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= FILL;
        else       r_state <= w_state_nxt;
    end

    assign o_s_ready = w_s_ready;
    assign o_f_valid = w_f_valid;
    assign o_wr_sel  = w_wr_sel;
    assign o_out_0   = r_out[0];
    assign o_out_1   = r_out[1];
    assign o_out_2   = r_out[2];
    assign o_out_3   = r_out[3];
    assign o_out_4   = r_out[4];
    assign o_out_5   = r_out[5];
    assign o_out_6   = r_out[6];
    assign o_out_7   = r_out[7];
    assign o_out_8   = r_out[8];
    assign o_out_9   = r_out[9];
endmodule
